// File: rtl/interval_averager.sv
// Batch averager for a signed interval measurer: re-arms it, captures settled counts,
// averages 2^LOG2_N good samples. Optional AVG_ROUND_EN selects round-half-up mean.
module interval_averager #(
  parameter int WIDTH         = 26,
  parameter int LOG2_N        = 4,
  parameter int REARM_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int OVF_LIMIT     = 8
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] meas_result,
  input  logic                    meas_stop,
  input  logic                    meas_overflow,
  output logic                    meas_clr,
  output logic signed [WIDTH-1:0] avg,
  output logic                    avg_valid,
  input  logic                    avg_ready,
  output logic                    err,
  output logic [LOG2_N:0]         ovf_count,
  output logic                    busy
);

  localparam int ACC_W = WIDTH + LOG2_N;
  localparam int CW    = LOG2_N + 1;
  localparam int TMAX  = (REARM_CYCLES > SETTLE_CYCLES) ? REARM_CYCLES : SETTLE_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);
  localparam logic [CW-1:0] N_SAMP  = CW'(1 << LOG2_N);
  localparam logic [CW-1:0] OVF_MAX = '1;
  localparam logic [CW-1:0] OVF_LIM = CW'(OVF_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SETTLE, S_CAPTURE, S_REARM, S_DIVIDE, S_DONE
  } state_t;

  state_t                   state, state_n;
  logic signed [ACC_W-1:0]  acc, acc_n;
  logic        [CW-1:0]     smp_cnt, cnt_n;
  logic        [CW-1:0]     ovf_n;
  logic                     err_n;
  logic signed [WIDTH-1:0]  avg_n, avg_div;
  logic                     is_ovf, is_ovf_n;
  logic        [TW-1:0]     timer, timer_n;

`ifdef AVG_ROUND_EN
  localparam int RND = (LOG2_N > 0) ? (1 << (LOG2_N - 1)) : 0;
  // One extra bit so the rounding bias can never wrap the accumulator.
  logic signed [ACC_W:0] acc_rnd;
  assign acc_rnd = {acc[ACC_W-1], acc} + (ACC_W+1)'(RND);
  assign avg_div = WIDTH'(acc_rnd >>> LOG2_N);
`else
  assign avg_div = WIDTH'(acc >>> LOG2_N);
`endif

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    cnt_n    = smp_cnt;
    ovf_n    = ovf_count;
    err_n    = err;
    avg_n    = avg;
    is_ovf_n = is_ovf;
    timer_n  = timer;
    case (state)
      S_IDLE: if (start) begin
        acc_n   = '0;
        cnt_n   = '0;
        ovf_n   = '0;
        err_n   = 1'b0;
        state_n = S_WAIT;
      end
      S_WAIT: if (meas_overflow || meas_stop) begin
        // Simultaneous stop and overflow counts as overflow.
        is_ovf_n = meas_overflow;
        timer_n  = TW'(SETTLE_CYCLES - 1);
        state_n  = S_SETTLE;
      end
      S_SETTLE: begin
        if (timer == '0) state_n = S_CAPTURE;
        else             timer_n = timer - 1'b1;
      end
      S_CAPTURE: begin
        if (is_ovf) begin
          if (ovf_count != OVF_MAX) ovf_n = ovf_count + 1'b1;
        end else begin
          acc_n = acc + ACC_W'(meas_result);
          cnt_n = smp_cnt + 1'b1;
        end
        if (cnt_n == N_SAMP) begin
          state_n = S_DIVIDE;
        end else if (ovf_n == OVF_LIM) begin
          state_n = S_DONE;
          err_n   = 1'b1;
          avg_n   = '0;
        end else begin
          timer_n = TW'(REARM_CYCLES - 1);
          state_n = S_REARM;
        end
      end
      S_REARM: begin
        if (timer == '0) state_n = S_WAIT;
        else             timer_n = timer - 1'b1;
      end
      S_DIVIDE: begin
        avg_n   = avg_div;
        state_n = S_DONE;
      end
      S_DONE: if (avg_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_IDLE;
      acc       <= '0;
      smp_cnt   <= '0;
      ovf_count <= '0;
      err       <= 1'b0;
      avg       <= '0;
      is_ovf    <= 1'b0;
      timer     <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      smp_cnt   <= cnt_n;
      ovf_count <= ovf_n;
      err       <= err_n;
      avg       <= avg_n;
      is_ovf    <= is_ovf_n;
      timer     <= timer_n;
    end
  end

  // Measurer is held cleared whenever no measurement is in flight.
  assign meas_clr  = (state == S_IDLE) || (state == S_REARM) ||
                     (state == S_DIVIDE) || (state == S_DONE);
  assign avg_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_interval_averager.sv
// Randomized self-checking bench for interval_averager with a batch-level mean model.
module tb_interval_averager;
  localparam int WIDTH = 26, LOG2_N = 2, REARM = 4, SETTLE = 3, OVF_LIM = 2;
  localparam int N = 1 << LOG2_N;
  localparam int TMO = 100;

  logic clk = 1'b0, clr = 1'b1, start = 1'b0;
  logic signed [WIDTH-1:0] meas_result = '0;
  logic meas_stop = 1'b0, meas_overflow = 1'b0, avg_ready = 1'b0;
  logic meas_clr, avg_valid, err, busy;
  logic signed [WIDTH-1:0] avg;
  logic [LOG2_N:0] ovf_count;

  int errors = 0, checks = 0;
  int smp_val[$];
  bit smp_ovf[$];

  interval_averager #(.WIDTH(WIDTH), .LOG2_N(LOG2_N), .REARM_CYCLES(REARM),
                      .SETTLE_CYCLES(SETTLE), .OVF_LIMIT(OVF_LIM)) dut (
    .clk(clk), .clr(clr), .start(start), .meas_result(meas_result),
    .meas_stop(meas_stop), .meas_overflow(meas_overflow), .meas_clr(meas_clr),
    .avg(avg), .avg_valid(avg_valid), .avg_ready(avg_ready), .err(err),
    .ovf_count(ovf_count), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic longint floordiv(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int rand_val();
    return int'($urandom_range(0, (1 << WIDTH) - 1)) - (1 << (WIDTH - 1));
  endfunction

  // Measurer model: wait for clear release, report after a random delay, hold until re-cleared.
  task automatic run_sample(input bit ovf, input int val, input bit chk_rearm);
    int cnt = 0;
    while (meas_clr && cnt < TMO) begin tick(); cnt++; end
    checks++;
    if (chk_rearm && cnt != REARM) begin
      errors++; $display("FAIL rearm_len: got %0d cycles, want %0d", cnt, REARM);
    end
    repeat ($urandom_range(0, 3)) tick();
    meas_result = WIDTH'(val);
    meas_stop = !ovf;
    meas_overflow = ovf;
    cnt = 0;
    while (!meas_clr && cnt < TMO) begin tick(); cnt++; end
    checks++;
    if (cnt != SETTLE + 2) begin
      errors++; $display("FAIL sample_latency: got %0d cycles, want %0d", cnt, SETTLE + 2);
    end
    meas_stop = 1'b0;
    meas_overflow = 1'b0;
  endtask

  task automatic run_batch(input string name, input int hold);
    int good = 0, novf = 0, i = 0, cnt = 0;
    longint sum = 0, mean;
    logic signed [WIDTH-1:0] exp_avg;
    bit exp_err;
    start = 1'b1; tick(); start = 1'b0;
    while (good < N && novf < OVF_LIM && i < smp_val.size()) begin
      run_sample(smp_ovf[i], smp_val[i], i > 0);
      if (smp_ovf[i]) novf++;
      else begin good++; sum += smp_val[i]; end
      i++;
    end
`ifdef AVG_ROUND_EN
    mean = floordiv(sum + N / 2, N);
`else
    mean = floordiv(sum, N);
`endif
    exp_err = (good < N);
    exp_avg = exp_err ? '0 : WIDTH'(mean);
    while (!avg_valid && cnt < TMO) begin tick(); cnt++; end
    checks++;
    if (avg_valid !== 1'b1 || avg !== exp_avg || err !== exp_err ||
        ovf_count !== (LOG2_N+1)'(novf) || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_result: valid=%b avg=%0d err=%b ovf=%0d busy=%b, want 1 %0d %b %0d 1",
               name, avg_valid, avg, err, ovf_count, busy, exp_avg, exp_err, novf);
    end
    for (int k = 0; k < hold; k++) begin
      start = (k % 3 == 1);
      tick();
      start = 1'b0;
      checks++;
      if (avg_valid !== 1'b1 || avg !== exp_avg || err !== exp_err || meas_clr !== 1'b1) begin
        errors++;
        $display("FAIL %s_hold: cycle %0d valid=%b avg=%0d err=%b clr=%b, want 1 %0d %b 1",
                 name, k, avg_valid, avg, err, meas_clr, exp_avg, exp_err);
      end
    end
    avg_ready = 1'b1; tick(); avg_ready = 1'b0;
    checks++;
    if (avg_valid !== 1'b0 || busy !== 1'b0 || meas_clr !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: valid=%b busy=%b clr=%b, want 0 0 1", name, avg_valid, busy, meas_clr);
    end
  endtask

  task automatic load(input int v0, input bit o0, input int v1, input bit o1,
                      input int v2, input bit o2, input int v3, input bit o3);
    smp_val = {v0, v1, v2, v3};
    smp_ovf = {o0, o1, o2, o3};
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (meas_clr !== 1'b1 || avg !== '0 || avg_valid !== 1'b0 || err !== 1'b0 ||
        ovf_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: clr=%b avg=%0d valid=%b err=%b ovf=%0d busy=%b, want 1 0 0 0 0 0",
               name, meas_clr, avg, avg_valid, err, ovf_count, busy);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; #1;
    check_idle("reset");
    tick(); clr = 1'b0; tick();
    avg_ready = 1'b1; tick(); avg_ready = 1'b0;
    check_idle("ready_when_idle");
  endtask

  task automatic test_basic();
    load(10, 0, 20, 0, 30, 0, 41, 0);  run_batch("pos", 0);
    load(-3, 0, -3, 0, -3, 0, -2, 0);  run_batch("neg", 0);
  endtask

  task automatic test_overflow_retry();
    load(5, 0, 99, 1, 5, 0, 5, 0);
    smp_val.push_back(5); smp_ovf.push_back(0);
    run_batch("retry", 0);
  endtask

  task automatic test_abort();
    load(3, 0, 77, 1, 4, 0, 88, 1);
    run_batch("abort", 0);
  endtask

  task automatic test_extremes();
    int mx = (1 << (WIDTH - 1)) - 1;
    load(mx, 0, mx, 0, mx, 0, mx, 0);          run_batch("max", 0);
    load(-mx - 1, 0, -mx - 1, 0, -mx - 1, 0, -mx - 1, 0); run_batch("min", 0);
  endtask

  task automatic test_hold();
    load(1, 0, 2, 0, 3, 0, -7, 0);
    run_batch("hold", 10);
  endtask

  task automatic test_random();
    for (int b = 0; b < 12; b++) begin
      smp_val.delete(); smp_ovf.delete();
      for (int s = 0; s < 8; s++) begin
        smp_val.push_back((b % 2) ? rand_val() : int'($urandom_range(0, 40)) - 20);
        smp_ovf.push_back($urandom_range(0, 5) == 0);
      end
      run_batch($sformatf("rand%0d", b), $urandom_range(0, 3));
    end
  endtask

  task automatic test_mid_reset();
    int cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    while (meas_clr && cnt < TMO) begin tick(); cnt++; end
    meas_result = WIDTH'(99); meas_stop = 1'b1;
    tick(); tick();
    #1 clr = 1'b1; #1;
    check_idle("mid_reset");
    meas_stop = 1'b0;
    tick(); clr = 1'b0; tick();
    check_idle("after_reset");
    load(7, 0, 7, 0, 7, 0, 7, 0);
    run_batch("clean", 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow_retry();
    test_abort();
    test_extremes();
    test_hold();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
